// File: rtl/axi_console_snoop_pkg.sv
// Shared types and helpers for the AXI console snoop: default console base,
// the queued byte event, channel address matching and byte-lane extraction.
package axi_console_snoop_pkg;

   localparam logic [31:0] CONSOLE_BASE = 32'h1000_0000;
   localparam int          MAX_CH       = 16;
   localparam int          MAX_CH_W     = 4;

   typedef struct packed {
      logic [MAX_CH_W-1:0] chan;
      logic [7:0]          data;
   } console_evt_t;

   typedef struct packed {
      logic                hit;
      logic [MAX_CH_W-1:0] chan;
   } ch_match_t;

   // First channel whose base equals the word-aligned address; hit=0 if none.
   function automatic ch_match_t match_chan(input logic [63:0] waddr,
                                            input logic [63:0] base,
                                            input logic [63:0] stride,
                                            input int          num_ch);
      ch_match_t r;
      r.hit  = 1'b0;
      r.chan = {MAX_CH_W{1'b0}};
      for (int k = 0; k < MAX_CH; k++) begin
         if ((k < num_ch) && !r.hit && (waddr == base + 64'(k) * stride)) begin
            r.hit  = 1'b1;
            r.chan = MAX_CH_W'(k);
         end
      end
      return r;
   endfunction

   function automatic logic [7:0] lane_byte(input logic [255:0] data, input logic [7:0] lane);
      return 8'(data >> {lane, 3'b000});
   endfunction

endpackage

// File: rtl/axi_console_snoop_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a push into a full FIFO is
// accepted only when a pop happens on the same edge.
module axi_console_snoop_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int             PTR_W   = $clog2(DEPTH);
   localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W:0]   wr_ptr;
   logic [PTR_W:0]   rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr[PTR_W-1:0]];

   // Storage and pointers; storage is cleared so the head reads zero after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= {(PTR_W+1){1'b0}};
         rd_ptr <= {(PTR_W+1){1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= {WIDTH{1'b0}};
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr[PTR_W-1:0]] <= din;
            wr_ptr                 <= wr_ptr + PTR_ONE;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

endmodule

// File: rtl/axi_console_snoop.sv
// Passive AXI AW/W snoop: pairs accepted beats in order, decodes console
// channel addresses and streams the addressed byte through an output FIFO.
module axi_console_snoop
   import axi_console_snoop_pkg::*;
#(
   parameter int                ADDR_W     = 32,
   parameter int                DATA_W     = 32,
   parameter int                NUM_CH     = 1,
   parameter logic [ADDR_W-1:0] CH_BASE    = CONSOLE_BASE,
   parameter int                CH_STRIDE  = 4,
   parameter int                PAIR_DEPTH = 4,
   parameter int                FIFO_DEPTH = 16,
   parameter int                SIM_PRINT  = 1,
   localparam int               BYTES      = DATA_W / 8,
   localparam int               CHAN_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                s_awvalid,
   input  logic                s_awready,
   input  logic [ADDR_W-1:0]   s_awaddr,
   input  logic                s_wvalid,
   input  logic                s_wready,
   input  logic [DATA_W-1:0]   s_wdata,
   input  logic [BYTES-1:0]    s_wstrb,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [7:0]          out_data,
   output logic [CHAN_W-1:0]   out_chan,
   output logic [15:0]         overflow_cnt,
   output logic                proto_err
);

   localparam int LANE_W = (BYTES > 1) ? $clog2(BYTES) : 1;

   logic                      aw_cap, w_cap;
   logic                      aw_full, aw_empty, w_full, w_empty;
   logic [ADDR_W-1:0]         aw_head;
   logic [DATA_W+BYTES-1:0]   w_head;
   logic                      pair;
   logic                      out_push, out_pop, out_full, out_empty;
   logic [LANE_W-1:0]         lane;
   logic [ADDR_W-1:0]         word_addr;
   ch_match_t                 hit;
   console_evt_t              pair_evt;
   console_evt_t              out_head;

   assign aw_cap = s_awvalid && s_awready;
   assign w_cap  = s_wvalid && s_wready;
   assign pair   = !aw_empty && !w_empty;

   axi_console_snoop_fifo #(.WIDTH(ADDR_W), .DEPTH(PAIR_DEPTH)) u_aw_q (
      .clk(clk), .rst(rst), .push(aw_cap && !aw_full), .din(s_awaddr),
      .pop(pair), .dout(aw_head), .full(aw_full), .empty(aw_empty)
   );

   axi_console_snoop_fifo #(.WIDTH(DATA_W + BYTES), .DEPTH(PAIR_DEPTH)) u_w_q (
      .clk(clk), .rst(rst), .push(w_cap && !w_full), .din({s_wstrb, s_wdata}),
      .pop(pair), .dout(w_head), .full(w_full), .empty(w_empty)
   );

   // Decode the paired heads into a candidate console byte.
   always_comb begin
      word_addr     = aw_head & ~ADDR_W'(BYTES - 1);
      lane          = (BYTES > 1) ? aw_head[LANE_W-1:0] : {LANE_W{1'b0}};
      hit           = match_chan(64'(word_addr), 64'(CH_BASE), 64'(CH_STRIDE), NUM_CH);
      pair_evt.chan = hit.chan;
      pair_evt.data = lane_byte(256'(w_head[DATA_W-1:0]), 8'(lane));
      if (pair && hit.hit) begin
         out_push = 1'(w_head[DATA_W+BYTES-1:DATA_W] >> lane);
      end else begin
         out_push = 1'b0;
      end
   end

   axi_console_snoop_fifo #(.WIDTH($bits(console_evt_t)), .DEPTH(FIFO_DEPTH)) u_out_q (
      .clk(clk), .rst(rst), .push(out_push), .din(pair_evt),
      .pop(out_pop), .dout(out_head), .full(out_full), .empty(out_empty)
   );

   assign out_valid = !out_empty;
   assign out_pop   = out_valid && out_ready;
   assign out_data  = out_head.data;
   assign out_chan  = CHAN_W'(out_head.chan);

   // Dropped-byte counter saturates rather than wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_cnt <= 16'h0000;
      end else if (out_push && out_full && !out_pop && (overflow_cnt != 16'hFFFF)) begin
         overflow_cnt <= overflow_cnt + 16'h0001;
      end else begin
         overflow_cnt <= overflow_cnt;
      end
   end

   // Sticky flag for a beat lost to a full AW or W queue.
   always_ff @(posedge clk) begin
      if (rst) begin
         proto_err <= 1'b0;
      end else if ((aw_cap && aw_full) || (w_cap && w_full)) begin
         proto_err <= 1'b1;
      end else begin
         proto_err <= proto_err;
      end
   end

`ifndef SYNTHESIS
   // Simulation console echo of every byte that actually enters the FIFO.
   always_ff @(posedge clk) begin
      if ((SIM_PRINT != 0) && !rst && out_push && (!out_full || out_pop)) begin
         $write("%c", pair_evt.data);
      end
   end
`endif

endmodule

// File: tb/tb_axi_console_snoop.sv
// Directed bench for axi_console_snoop: stimulus pushes expected bytes into a
// scoreboard queue, a negedge monitor pops and compares every accepted byte.
module tb_axi_console_snoop;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        s_awvalid = 1'b0, s_awready = 1'b1;
   logic [31:0] s_awaddr = 32'h0;
   logic        s_wvalid = 1'b0, s_wready = 1'b1;
   logic [31:0] s_wdata = 32'h0;
   logic [3:0]  s_wstrb = 4'h0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [7:0]  out_data;
   logic [0:0]  out_chan;
   logic [15:0] overflow_cnt;
   logic        proto_err;

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [8:0]  sb [$];
   logic [8:0]  mon_exp;

   always #5 clk = ~clk;

   axi_console_snoop #(
      .ADDR_W(32), .DATA_W(32), .NUM_CH(2), .CH_BASE(32'h1000_0000), .CH_STRIDE(4),
      .PAIR_DEPTH(4), .FIFO_DEPTH(16), .SIM_PRINT(0)
   ) dut (
      .clk(clk), .rst(rst),
      .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
      .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_chan(out_chan),
      .overflow_cnt(overflow_cnt), .proto_err(proto_err)
   );

   // Scoreboard monitor: every accepted output byte must match the queue head.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         n_chk++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_byte: got chan %0d data %02h, required no output", out_chan, out_data);
         end else begin
            mon_exp = sb.pop_front();
            if ({out_chan, out_data} !== mon_exp) begin
               n_fail++;
               $display("FAIL byte_stream: got chan %0d data %02h, required chan %0d data %02h",
                        out_chan, out_data, mon_exp[8], mon_exp[7:0]);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      s_awvalid = 1'b1; s_awaddr = a;
      s_wvalid  = 1'b1; s_wdata  = d; s_wstrb = s;
      @(posedge clk); #1;
      s_awvalid = 1'b0; s_wvalid = 1'b0;
   endtask

   task automatic aw_only(input logic [31:0] a);
      s_awvalid = 1'b1; s_awaddr = a;
      @(posedge clk); #1;
      s_awvalid = 1'b0;
   endtask

   task automatic w_only(input logic [31:0] d, input logic [3:0] s);
      s_wvalid = 1'b1; s_wdata = d; s_wstrb = s;
      @(posedge clk); #1;
      s_wvalid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      idle(3);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_out_valid", 32'(out_valid), 32'h0);
      chk("reset_out_data", 32'(out_data), 32'h0);
      chk("reset_out_chan", 32'(out_chan), 32'h0);
      chk("reset_overflow_cnt", 32'(overflow_cnt), 32'h0);
      chk("reset_proto_err", 32'(proto_err), 32'h0);
      @(posedge clk); #1;

      // 1: same-cycle AW/W, byte visible one edge after the pair is popped
      sb.push_back({1'b0, 8'h41});
      wr(32'h1000_0000, 32'h0000_0041, 4'h1);
      @(negedge clk);
      chk("latency_after_capture_edge", 32'(out_valid), 32'h0);
      @(negedge clk);
      chk("latency_after_pair_edge", 32'(out_valid), 32'h1);
      @(posedge clk); #1;
      idle(3);

      // 2: W leads AW by three beats
      for (int i = 0; i < 3; i++) w_only(32'h0063_6261, 4'hF);
      idle(2);
      sb.push_back({1'b0, 8'h61});
      sb.push_back({1'b0, 8'h62});
      sb.push_back({1'b0, 8'h63});
      for (int i = 0; i < 3; i++) aw_only(32'h1000_0000 + 32'(i));
      idle(5);
      chk("w_leads_proto_err", 32'(proto_err), 32'h0);

      // 3: second channel, then an unmapped address
      sb.push_back({1'b1, 8'h5A});
      wr(32'h1000_0004, 32'h0000_005A, 4'h1);
      wr(32'h2000_0000, 32'h0000_0077, 4'h1);
      idle(5);
      chk("chan1_and_unmapped_drained", 32'(sb.size()), 32'h0);

      // 4: lane strobe gating
      wr(32'h1000_0001, 32'h0000_4200, 4'h1);
      idle(3);
      sb.push_back({1'b0, 8'h42});
      wr(32'h1000_0001, 32'h0000_4200, 4'h2);
      idle(5);
      chk("lane1_drained", 32'(sb.size()), 32'h0);

      // 5: overflow with the consumer stalled
      out_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (i < 16) sb.push_back({1'b0, 8'(8'h30 + i)});
         wr(32'h1000_0000, 32'h30 + 32'(i), 4'h1);
      end
      idle(3);
      @(negedge clk);
      chk("overflow_cnt", 32'(overflow_cnt), 32'h4);
      chk("hold_valid", 32'(out_valid), 32'h1);
      chk("hold_data", 32'(out_data), 32'h30);
      idle(2);
      @(negedge clk);
      chk("hold_data_stable", 32'(out_data), 32'h30);
      chk("hold_chan_stable", 32'(out_chan), 32'h0);
      @(posedge clk); #1;
      out_ready = 1'b1;
      idle(20);
      chk("overflow_drained", 32'(sb.size()), 32'h0);

      // 6: AW queue overflow, then reset mid-stream with queued state
      out_ready = 1'b0;
      wr(32'h1000_0000, 32'h0000_0073, 4'h1);
      wr(32'h1000_0000, 32'h0000_0074, 4'h1);
      for (int i = 0; i < 5; i++) aw_only(32'h1000_0004);
      @(negedge clk);
      chk("aw_overflow_proto_err", 32'(proto_err), 32'h1);
      @(posedge clk); #1;
      rst = 1'b1;
      wr(32'h1000_0000, 32'h0000_0099, 4'h1);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_out_valid", 32'(out_valid), 32'h0);
      chk("midrst_out_data", 32'(out_data), 32'h0);
      chk("midrst_out_chan", 32'(out_chan), 32'h0);
      chk("midrst_overflow_cnt", 32'(overflow_cnt), 32'h0);
      chk("midrst_proto_err", 32'(proto_err), 32'h0);
      @(posedge clk); #1;
      out_ready = 1'b1;
      sb.push_back({1'b0, 8'h52});
      wr(32'h1000_0000, 32'h0000_0052, 4'h1);
      idle(8);
      chk("post_reset_drained", 32'(sb.size()), 32'h0);
      chk("post_reset_proto_err", 32'(proto_err), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
